// File: rtl/quicksort_ctrl_if.sv
// Handshake bundle between the quicksort controller and its partition stage.
// The controller launches one index range at a time and waits for the pivot result.
interface quicksort_ctrl_if #(parameter int ARR_WIDTH = 4);
  logic                   part_start;
  logic [3:0]             part_lo;
  logic [3:0]             part_hi;
  logic [ARR_WIDTH*4-1:0] part_array;
  logic                   part_ready;
  logic [3:0]             part_pivot;
  logic [ARR_WIDTH*4-1:0] part_array_out;

  modport master (
    output part_start, part_lo, part_hi, part_array,
    input  part_ready, part_pivot, part_array_out
  );

  modport slave (
    input  part_start, part_lo, part_hi, part_array,
    output part_ready, part_pivot, part_array_out
  );
endinterface

// File: rtl/quicksort_ctrl.sv
// Iterative quicksort sequencer: keeps a LIFO of {lo,hi} ranges and hands each one
// to an external partition stage, pushing the two sub-ranges around the returned pivot.
module quicksort_ctrl #(
  parameter int ARR_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ARR_WIDTH*4-1:0] array_in,
  output logic                   ready,
  output logic                   busy,
  output logic                   overflow,
  output logic [ARR_WIDTH*4-1:0] array_out,
  quicksort_ctrl_if.master       part
);
  localparam int          AW    = ARR_WIDTH * 4;
  localparam logic [4:0]  DEPTH = 5'(ARR_WIDTH);

  typedef enum logic [2:0] {IDLE, POP, LAUNCH, WAIT, PUSH, DONE} state_t;
  state_t state, state_nxt;

  logic [AW-1:0]             arr;
  logic [ARR_WIDTH-1:0][3:0] stk_lo, stk_hi;
  logic [4:0]                sp, sp_b;
  logic [3:0]                lo, hi, p;
  logic [3:0]                top_lo, top_hi;
  logic                      accept, empty, in_range;
  logic                      push_a, push_b, ok_a, ok_b, ovf_a, ovf_b;

  assign accept    = start && (state == IDLE || state == DONE);
  assign empty     = (sp == 5'd0);
  assign in_range  = (part.part_pivot >= lo) && (part.part_pivot <= hi);

  assign array_out       = arr;
  assign part.part_array = arr;
  assign part.part_lo    = lo;
  assign part.part_hi    = hi;

  // p > lo is tested first so p-1 is only meaningful when it cannot wrap
  assign push_a = (p > lo) && ((p - 4'd1) > lo);
  assign push_b = ({1'b0, p} + 5'd1) < {1'b0, hi};
  assign ok_a   = push_a && (sp < DEPTH);
  assign ovf_a  = push_a && !(sp < DEPTH);
  assign sp_b   = sp + {4'd0, ok_a};
  assign ok_b   = push_b && (sp_b < DEPTH);
  assign ovf_b  = push_b && !(sp_b < DEPTH);

  always_comb begin
    top_lo = '0;
    top_hi = '0;
    for (int i = 0; i < ARR_WIDTH; i++)
      if (sp == 5'(i + 1)) begin
        top_lo = stk_lo[i];
        top_hi = stk_hi[i];
      end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    part.part_start = 1'b0;
    ready           = 1'b0;
    busy            = 1'b1;
    unique case (state)
      IDLE:    begin busy = 1'b0; if (start) state_nxt = POP; end
      DONE:    begin busy = 1'b0; ready = 1'b1; if (start) state_nxt = POP; end
      POP:     state_nxt = empty ? DONE : LAUNCH;
      LAUNCH:  begin part.part_start = 1'b1; state_nxt = WAIT; end
      WAIT:    if (part.part_ready) state_nxt = PUSH;
      PUSH:    state_nxt = POP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      arr      <= '0;
      sp       <= '0;
      lo       <= '0;
      hi       <= '0;
      p        <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        arr      <= array_in;
        overflow <= 1'b0;
        if (ARR_WIDTH > 1) begin
          stk_lo[0] <= 4'd0;
          stk_hi[0] <= 4'(ARR_WIDTH - 1);
          sp        <= 5'd1;
        end else begin
          sp <= 5'd0;
        end
      end
      case (state)
        POP: if (!empty) begin
          lo <= top_lo;
          hi <= top_hi;
          sp <= sp - 5'd1;
        end
        WAIT: if (part.part_ready) begin
          arr <= part.part_array_out;
          // a pivot outside the launched range degrades to lo so the pushes stay sane
          p   <= in_range ? part.part_pivot : lo;
        end
        PUSH: begin
          for (int i = 0; i < ARR_WIDTH; i++) begin
            if (ok_a && sp == 5'(i)) begin
              stk_lo[i] <= lo;
              stk_hi[i] <= p - 4'd1;
            end
            if (ok_b && sp_b == 5'(i)) begin
              stk_lo[i] <= p + 4'd1;
              stk_hi[i] <= hi;
            end
          end
          sp <= sp_b + {4'd0, ok_b};
          if (ovf_a || ovf_b) overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_quicksort_ctrl.sv
// Bench for quicksort_ctrl: Lomuto partition model on the slave side, sorted results
// queued at start and compared when ready rises; a second 1-element instance.
module tb_quicksort_ctrl;
  localparam int N = 4;

  logic          clock = 1'b0, reset = 1'b0, start = 1'b0;
  logic [15:0]   array_in = '0;
  logic          ready, busy, overflow;
  logic [15:0]   array_out;
  logic          start1 = 1'b0;
  logic [3:0]    array_in1 = 4'h7;
  logic          ready1, busy1, overflow1;
  logic [3:0]    array_out1;

  quicksort_ctrl_if #(.ARR_WIDTH(N)) pif ();
  quicksort_ctrl_if #(.ARR_WIDTH(1)) pif1 ();

  quicksort_ctrl #(.ARR_WIDTH(N)) dut (
    .clock(clock), .reset(reset), .start(start), .array_in(array_in),
    .ready(ready), .busy(busy), .overflow(overflow), .array_out(array_out), .part(pif)
  );
  quicksort_ctrl #(.ARR_WIDTH(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .array_in(array_in1),
    .ready(ready1), .busy(busy1), .overflow(overflow1), .array_out(array_out1), .part(pif1)
  );
  assign pif1.part_ready     = 1'b0;
  assign pif1.part_pivot     = 4'd0;
  assign pif1.part_array_out = 4'd0;

  always #5 clock = ~clock;

  typedef struct { string tag; logic [15:0] arr; } exp_t;
  exp_t sbq[$];

  int n_assert = 0, n_fail = 0;
  int launches = 0, launches1 = 0;
  int part_delay = 2;
  bit bad_pivot = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_sort(input logic [15:0] a);
    logic [3:0] e [N];
    logic [3:0] t;
    logic [15:0] r;
    for (int k = 0; k < N; k++) e[k] = a[4*k +: 4];
    for (int x = 0; x < N; x++)
      for (int y = 0; y < N - 1 - x; y++)
        if (e[y] > e[y+1]) begin t = e[y]; e[y] = e[y+1]; e[y+1] = t; end
    for (int k = 0; k < N; k++) r[4*k +: 4] = e[k];
    return r;
  endfunction

  task automatic lomuto(input logic [15:0] ain, input int lo, input int hi,
                        output logic [15:0] aout, output logic [3:0] pv);
    logic [3:0] e [N];
    logic [3:0] t;
    int i;
    if (hi > N - 1) hi = N - 1;
    if (lo > hi) lo = hi;
    for (int k = 0; k < N; k++) e[k] = ain[4*k +: 4];
    i = lo;
    for (int j = lo; j < hi; j++)
      if (e[j] < e[hi]) begin t = e[i]; e[i] = e[j]; e[j] = t; i++; end
    t = e[i]; e[i] = e[hi]; e[hi] = t;
    for (int k = 0; k < N; k++) aout[4*k +: 4] = e[k];
    pv = 4'(i);
  endtask

  // Partition stage model; launched range must stay stable and unrepeated while it works
  initial begin : part_model
    logic [3:0]  mlo, mhi, pv;
    logic [15:0] ain, aout;
    bit aborted;
    pif.part_ready = 1'b0; pif.part_pivot = '0; pif.part_array_out = '0;
    forever begin
      @(negedge clock);
      if (reset && pif.part_start) begin
        launches++;
        mlo = pif.part_lo; mhi = pif.part_hi; ain = pif.part_array;
        lomuto(ain, int'(mlo), int'(mhi), aout, pv);
        if (bad_pivot) begin pv = 4'hF; aout = ain; end
        aborted = 1'b0;
        for (int k = 0; k < part_delay; k++) begin
          @(negedge clock);
          if (!reset) begin aborted = 1'b1; break; end
          chk("hold_lo", 64'(pif.part_lo), 64'(mlo));
          chk("hold_hi", 64'(pif.part_hi), 64'(mhi));
          chk("hold_array", 64'(pif.part_array), 64'(ain));
          chk("no_repulse", 64'(pif.part_start), 64'(0));
        end
        if (!aborted) begin
          pif.part_ready = 1'b1; pif.part_pivot = pv; pif.part_array_out = aout;
          @(negedge clock);
          pif.part_ready = 1'b0;
        end
      end
    end
  end

  always @(negedge clock) if (pif1.part_start) launches1++;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic start_sort(input logic [15:0] a, input logic [15:0] exp, input string tag);
    exp_t e;
    e.tag = tag; e.arr = exp;
    sbq.push_back(e);
    @(negedge clock); array_in = a; start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_done();
    exp_t e;
    int c = 0;
    while (!ready && c < 3000) begin @(negedge clock); c++; end
    e = sbq.pop_front();
    chk({e.tag, "_ready"}, 64'(ready), 64'(1));
    chk({e.tag, "_busy"}, 64'(busy), 64'(0));
    chk({e.tag, "_array"}, 64'(array_out), 64'(e.arr));
    chk({e.tag, "_part_array"}, 64'(pif.part_array), 64'(e.arr));
    chk({e.tag, "_ovf"}, 64'(overflow), 64'(0));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 64'(ready), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_ovf"}, 64'(overflow), 64'(0));
    chk({tag, "_pstart"}, 64'(pif.part_start), 64'(0));
    chk({tag, "_plo"}, 64'(pif.part_lo), 64'(0));
    chk({tag, "_phi"}, 64'(pif.part_hi), 64'(0));
    chk({tag, "_array"}, 64'(array_out), 64'(0));
  endtask

  initial begin : stim
    int l0, c;
    logic [15:0] r;

    repeat (3) @(negedge clock);
    chk_reset("rst");
    chk("rst1_ready", 64'(ready1), 64'(0));
    reset = 1'b1;

    // canonical example: 2,0,5,1 -> two partition launches
    l0 = launches;
    start_sort(16'h1502, 16'h5210, "basic");
    wait_done();
    chk("basic_launches", 64'(launches - l0), 64'(2));

    start_sort(16'h5210, 16'h5210, "sorted");
    wait_done();
    start_sort(16'h3333, 16'h3333, "equal");
    wait_done();

    for (int t = 0; t < 3; t++) begin
      r = 16'($urandom);
      start_sort(r, ref_sort(r), $sformatf("rand%0d", t));
      wait_done();
    end

    // slow partition stage: stability checked by the model every waiting cycle
    part_delay = 50;
    l0 = launches;
    start_sort(16'h3A7C, 16'hCA73, "slow");
    wait_done();
    chk("slow_launches_nonzero", 64'(launches - l0 > 0), 64'(1));
    part_delay = 2;

    // start while busy must be ignored
    start_sort(16'h4182, 16'h8421, "busy_start");
    repeat (3) @(negedge clock);
    chk("busy_before_pulse", 64'(busy), 64'(1));
    array_in = 16'h0F0F; start = 1'b1;
    @(negedge clock); start = 1'b0; array_in = 16'h0000;
    wait_done();

    // out-of-range pivot behaves like pivot=lo: ranges [0,3],[1,3],[2,3]
    bad_pivot = 1'b1;
    l0 = launches;
    start_sort(16'h1502, 16'h1502, "bad_pivot");
    wait_done();
    chk("bad_pivot_launches", 64'(launches - l0), 64'(3));
    bad_pivot = 1'b0;

    // reset in the middle of WAIT aborts the sort
    part_delay = 50;
    @(negedge clock); array_in = 16'h1502; start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (8) @(negedge clock);
    chk("mid_busy", 64'(busy), 64'(1));
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset("midrst");
    reset = 1'b1;
    part_delay = 2;
    l0 = launches;
    repeat (5) @(negedge clock);
    chk("post_rst_no_launch", 64'(launches - l0), 64'(0));
    chk("post_rst_idle", 64'(busy), 64'(0));
    start_sort(16'h1502, 16'h5210, "after_rst");
    wait_done();

    // single-element instance finishes with no partition launch
    @(negedge clock); start1 = 1'b1;
    @(negedge clock); start1 = 1'b0;
    c = 0;
    while (!ready1 && c < 100) begin @(negedge clock); c++; end
    chk("w1_ready", 64'(ready1), 64'(1));
    chk("w1_array", 64'(array_out1), 64'(4'h7));
    chk("w1_launches", 64'(launches1), 64'(0));
    chk("w1_ovf", 64'(overflow1), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/quicksort_ctrl.md
QUICKSORT_CTRL -- requirements
Module: quicksort_ctrl

Interface
REQ-001 Parameter ARR_WIDTH, default 4: number of array elements; each element is 4 bits; legal range is 1..15.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-004 start  input  1  request to sort array_in; honoured only in IDLE or DONE.
REQ-005 array_in  input  ARR_WIDTH*4  unsorted array; element i occupies bits [4i+3:4i].
REQ-006 ready  output  1  sort complete; array_out is valid while high.
REQ-007 busy  output  1  sort in progress.
REQ-008 overflow  output  1  sticky flag: a range stack push was attempted while the stack was full.
REQ-009 array_out  output  ARR_WIDTH*4  working or sorted array, same packing as array_in.
REQ-010 part_start  output  1  one-cycle launch pulse to the downstream partition stage.
REQ-011 part_lo, part_hi  output  4 each  inclusive index range to partition.
REQ-012 part_array  output  ARR_WIDTH*4  working array presented to partition; equal to array_out at all times.
REQ-013 part_ready  input  1  partition done; part_pivot and part_array_out are valid while high.
REQ-014 part_pivot  input  4  final pivot index returned by partition.
REQ-015 part_array_out  input  ARR_WIDTH*4  array after partitioning.

Function
REQ-016 Range stack: LIFO of {lo,hi} pairs, depth ARR_WIDTH, with a 5-bit pointer sp.
REQ-017 FSM states: IDLE, POP, LAUNCH, WAIT, PUSH, DONE.
REQ-018 IDLE/DONE with start=1: register array_in into the working array, clear overflow and ready, set busy, and push {0,ARR_WIDTH-1} if ARR_WIDTH>1; next state POP.
REQ-019 POP, stack empty: next state DONE.
REQ-020 POP, stack non-empty: pop the top entry into part_lo/part_hi; next state LAUNCH.
REQ-021 LAUNCH: assert part_start for exactly this one cycle; next state WAIT.
REQ-022 WAIT: hold part_lo, part_hi and part_array stable until part_ready=1.
REQ-023 WAIT with part_ready=1: capture part_array_out into the working array and part_pivot into register p; next state PUSH.
REQ-024 A part_ready that is already high in the LAUNCH cycle is ignored; only part_ready in WAIT is acted upon.
REQ-025 PUSH: push {lo,p-1} only if p>lo+1, evaluating p>lo before forming p-1 so that index 0 cannot underflow.
REQ-026 PUSH: then push {p+1,hi} only if p+1<hi; both pushes complete in the single PUSH cycle; next state POP.
REQ-027 A push with sp==ARR_WIDTH is dropped and sets overflow; sorting continues.
REQ-028 A part_pivot outside [lo,hi] is treated as p=lo for the push decision (REQ-025/026).
REQ-029 DONE: ready=1, busy=0; array_out holds its value until the next accepted start.
REQ-030 start outside IDLE/DONE is ignored with no state change.
REQ-031 Result ordering: on completion, array_out elements are ascending by index (element 0 smallest).

Reset
REQ-032 When reset=0 at a clock edge: state=IDLE, sp=0, ready=0, busy=0, overflow=0, part_start=0, part_lo=0, part_hi=0, and the working array (array_out) =0.
REQ-033 Reset asserted in any state, including mid-sort in WAIT, aborts the sort; no part_start is issued until a new start is accepted after reset is released.

Verification
REQ-034 ARR_WIDTH=4, array_in=16'h1502 (elements 2,0,5,1), with a Lomuto partition model -> ready=1 and array_out=16'h5210; overflow=0.
REQ-035 Input already sorted (16'h5210) and input all equal (16'h3333) -> ready=1, array_out unchanged, overflow=0.
REQ-036 ARR_WIDTH=1, array_in=4'h7 -> DONE reached with no part_start pulse; array_out=4'h7.
REQ-037 part_ready held low for 50 cycles during WAIT -> part_lo, part_hi and part_array stay stable and exactly one part_start pulse is issued per range.
REQ-038 reset=0 asserted during WAIT, then released, then a new start -> all outputs read their reset values, after which a correct sort completes.
REQ-039 start pulsed while busy=1 -> ignored; the final result equals that of the original input.
